dmem_responder: RTL

Responder side of the MEM-stage data memory interface. It accepts one load/store request at a time from the memory stage over a valid/ready handshake and performs the access after a fixed, parameterised latency. It supports word, halfword and byte accesses in big-endian order, and returns read data together with an error flag. It replaces the zero-latency memory model behind the MEM stage, so pipeline stall logic can be exercised against realistic access times.

---
 rtl/dmem_responder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Fixed-latency data memory responder for the MEM stage: one valid/ready request at a time,
// big-endian word/halfword/byte access, response strobe with error flag.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h8002_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [0:31] address,
    input  logic        wren,
    input  logic [0:1]  size,
    input  logic [0:31] data_in,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [0:31] data_out
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e      state_q;
    logic [3:0]  count_q;
    logic [0:31] addr_q;
    logic [0:31] wdata_q;
    logic        wren_q;
    logic [0:1]  size_q;

    // Backing store; deliberately has no reset.
    logic [0:31] mem [DEPTH_WORDS];

    logic [0:31]      word_idx;
    logic [IDX_W-1:0] mem_idx;
    logic [0:1]       lane;
    logic             access_err;
    logic             do_access;
    logic [0:31]      cur_word;
    logic [0:31]      merged;
    logic [0:31]      load_data;

    always_comb begin
        word_idx   = (addr_q - BASE_ADDR) >> 2;
        mem_idx    = IDX_W'(word_idx);
        lane       = addr_q[30:31];
        access_err = 1'b0;
        if (size_q == 2'b11) begin
            access_err = 1'b1;
        end
        if (size_q == 2'b00 && lane != 2'b00) begin
            access_err = 1'b1;
        end
        if (size_q == 2'b01 && lane[1]) begin
            access_err = 1'b1;
        end
        if (addr_q < BASE_ADDR || word_idx >= DEPTH_WORDS) begin
            access_err = 1'b1;
        end
        do_access = (state_q == StWait) && (count_q == 4'd0);
    end

    // Lane 0 is the most significant byte (big-endian); loads are zero-extended.
    always_comb begin
        cur_word  = mem[mem_idx];
        merged    = cur_word;
        load_data = '0;
        case (size_q)
            2'b00: begin
                merged    = wdata_q;
                load_data = cur_word;
            end
            2'b01: begin
                merged[{lane[0], 4'b0000} +: 16] = wdata_q[16:31];
                load_data[16:31]                 = cur_word[{lane[0], 4'b0000} +: 16];
            end
            2'b10: begin
                merged[{lane, 3'b000} +: 8] = wdata_q[24:31];
                load_data[24:31]            = cur_word[{lane, 3'b000} +: 8];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (do_access && wren_q && !access_err) begin
            mem[mem_idx] <= merged;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            count_q    <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wren_q     <= 1'b0;
            size_q     <= 2'b00;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            data_out   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        addr_q    <= address;
                        wdata_q   <= data_in;
                        wren_q    <= wren;
                        size_q    <= size;
                        count_q   <= 4'(LATENCY - 1);
                        req_ready <= 1'b0;
                        state_q   <= StWait;
                    end
                end
                StWait: begin
                    if (count_q == 4'd0) begin
                        resp_valid <= 1'b1;
                        resp_err   <= access_err;
                        if (access_err) begin
                            data_out <= '0;
                        end else if (wren_q) begin
                            data_out <= merged;
                        end else begin
                            data_out <= load_data;
                        end
                        state_q <= StResp;
                    end else begin
                        count_q <= count_q - 4'd1;
                    end
                end
                StResp: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state_q    <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
